// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade driver and its per-channel ramps.
package led_pkg;

  localparam int unsigned DEFAULT_PWM_BITS = 8;
  localparam int unsigned DEFAULT_FADE_DIV = 50000;

  typedef logic [DEFAULT_PWM_BITS-1:0] level_t;

  // Full-brightness level for a given PWM width.
  function automatic int unsigned level_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating brightness ramp stepped on tick, plus the PWM compare.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                enable,
  input  logic                target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(level_max(PWM_BITS));

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] target_level;

  assign target_level = target ? LEVEL_MAX : '0;
  assign at_target    = (level == target_level);

  always_comb begin
    level_next = level;
    if (!enable) begin
      level_next = target_level;
    end else if (tick) begin
      if (target && (level != LEVEL_MAX)) begin
        level_next = level + 1'b1;
      end else if (!target && (level != '0)) begin
        level_next = level - 1'b1;
      end
    end
  end

  // Full level is forced high so the top brightness has no one-count dark slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      level <= level_next;
      if (!enable) begin
        led <= target;
      end else begin
        led <= (level == LEVEL_MAX) || (pwm_cnt < level);
      end
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// Fades each LED toward the on/off target coming from the PIO out_port, with a
// bypass mode that mirrors the targets directly.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS,
  parameter int unsigned FADE_DIV = DEFAULT_FADE_DIV
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] led_in,
  input  logic              enable,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int unsigned PRESC_W = $clog2(FADE_DIV);

  logic [N_LEDS-1:0]   led_in_r;
  logic [N_LEDS-1:0]   at_target;
  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick = enable && (presc == PRESC_W'(FADE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_in_r <= '0;
      presc    <= '0;
      pwm_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      led_in_r <= led_in;
      pwm_cnt  <= pwm_cnt + 1'b1;
      // Held at zero in bypass so the first tick after enabling is a full period away.
      if (!enable || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
      busy <= ~&at_target;
    end
  end

  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_ch
      led_fade_channel #(
        .PWM_BITS (PWM_BITS)
      ) u_ch (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .enable    (enable),
        .target    (led_in_r[gi]),
        .pwm_cnt   (pwm_cnt),
        .led       (led_out[gi]),
        .at_target (at_target[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver (4 LEDs, 4-bit PWM, fade step every 4 clocks).
module tb_led_fade_driver;

  localparam int NL   = 4;
  localparam int PB   = 4;
  localparam int FD   = 4;
  localparam int LMAX = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NL-1:0] led_in = '0;
  logic          enable = 1'b0;
  logic [NL-1:0] led_out;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  led_fade_driver #(.N_LEDS(NL), .PWM_BITS(PB), .FADE_DIV(FD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_in  (led_in),
    .enable  (enable),
    .led_out (led_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural reference: brightness in plain integers, saturated by clamping.
  logic [NL-1:0] m_in_r;
  logic [NL-1:0] m_led;
  logic          m_busy;
  int            m_presc;
  int            m_pwm;
  int            m_level [NL];

  function automatic int clamp_level(input int v);
    if (v < 0) return 0;
    if (v > LMAX) return LMAX;
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_in_r  <= '0;
      m_led   <= '0;
      m_busy  <= 1'b0;
      m_presc <= 0;
      m_pwm   <= 0;
      for (int i = 0; i < NL; i++) m_level[i] <= 0;
    end else begin
      bit tk;
      bit bv;
      int goal;
      tk = enable && (m_presc == FD - 1);
      bv = 1'b0;
      m_presc <= (enable && !tk) ? m_presc + 1 : 0;
      m_pwm   <= (m_pwm + 1) % (LMAX + 1);
      m_in_r  <= led_in;
      for (int i = 0; i < NL; i++) begin
        goal = m_in_r[i] ? LMAX : 0;
        if (m_level[i] != goal) bv = 1'b1;
        if (!enable) begin
          m_level[i] <= goal;
          m_led[i]   <= m_in_r[i];
        end else begin
          m_led[i] <= (m_level[i] == LMAX) || (m_pwm < m_level[i]);
          if (tk) m_level[i] <= clamp_level(m_level[i] + (m_in_r[i] ? 1 : -1));
        end
      end
      m_busy <= bv;
    end
  end

  function automatic int get_level(input int ch);
    case (ch)
      0:       return int'(dut.g_ch[0].u_ch.level);
      1:       return int'(dut.g_ch[1].u_ch.level);
      2:       return int'(dut.g_ch[2].u_ch.level);
      default: return int'(dut.g_ch[3].u_ch.level);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge against the model.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check("model_led_out", 32'(led_out), 32'(m_led));
      check("model_busy", 32'(busy), 32'(m_busy));
    end
  endtask

  task automatic wait_level(input int ch, input int val, input string name);
    int k;
    k = 0;
    while ((get_level(ch) != val) && (k < 200)) begin
      cyc(1);
      k++;
    end
    check(name, 32'(get_level(ch)), 32'(val));
  endtask

  typedef struct {
    logic          en;
    logic [NL-1:0] din;
    int            waitc;
    logic [NL-1:0] exp_led;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 4'b1010, 3, 4'b1010, 1'b0};
    vecs[1] = '{1'b0, 4'b0101, 3, 4'b0101, 1'b0};
    vecs[2] = '{1'b0, 4'b1100, 3, 4'b1100, 1'b0};
    vecs[3] = '{1'b0, 4'b0011, 3, 4'b0011, 1'b0};
    vecs[4] = '{1'b0, 4'b1111, 3, 4'b1111, 1'b0};
    vecs[5] = '{1'b0, 4'b0000, 3, 4'b0000, 1'b0};

    // Reset with all targets on
    led_in = 4'b1111;
    enable = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_led_out", 32'(led_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    cyc(3);
    check("reset_hold_led_out", 32'(led_out), 32'h0);
    reset_n = 1'b1;
    cyc(1);
    check("release_lat1", 32'(led_out), 32'h0);
    cyc(1);
    check("release_lat2", 32'(led_out), 32'hF);
    cyc(1);
    check("release_busy", 32'(busy), 32'h0);
    $display("reset: led_out=%b busy=%b", led_out, busy);

    // Bypass latency by hand, then the vector table
    led_in = 4'b1010;
    cyc(1);
    check("bypass_lat1_old", 32'(led_out), 32'hF);
    cyc(1);
    check("bypass_lat2_new", 32'(led_out), 32'hA);
    for (int v = 0; v < 6; v++) begin
      enable = vecs[v].en;
      led_in = vecs[v].din;
      cyc(vecs[v].waitc);
      check("vec_led_out", 32'(led_out), 32'(vecs[v].exp_led));
      check("vec_busy", 32'(busy), 32'(vecs[v].exp_busy));
      $display("vec %0d: led_in=%b led_out=%b busy=%b", v, vecs[v].din, led_out, busy);
    end

    // Fade up LED 0
    enable = 1'b1;
    led_in = 4'b0001;
    cyc(1);
    check("fade_busy_lat1", 32'(busy), 32'h0);
    cyc(1);
    check("fade_busy_lat2", 32'(busy), 32'h1);
    cyc(57);
    check("fade_level_59", 32'(get_level(0)), 32'd14);
    cyc(1);
    check("fade_level_60", 32'(get_level(0)), 32'd15);
    check("fade_busy_at_top", 32'(busy), 32'h1);
    cyc(1);
    check("fade_busy_fall", 32'(busy), 32'h0);
    for (int k = 0; k < 32; k++) begin
      cyc(1);
      check("full_on_steady", 32'(led_out), 32'h1);
    end
    $display("fade up: level0=%0d led_out=%b busy=%b", get_level(0), led_out, busy);

    // Reversal on LED 1 at level 5
    led_in = 4'b0011;
    wait_level(1, 5, "rev_reach5");
    led_in = 4'b0001;
    cyc(3);
    check("rev_hold5", 32'(get_level(1)), 32'd5);
    cyc(1);
    check("rev_first_step", 32'(get_level(1)), 32'd4);
    cyc(16);
    check("rev_level0", 32'(get_level(1)), 32'd0);
    check("rev_busy_at_zero", 32'(busy), 32'h1);
    cyc(1);
    check("rev_busy_fall", 32'(busy), 32'h0);
    $display("reversal: level1=%0d busy=%b", get_level(1), busy);

    // Duty at level 8 on LED 2: high while the pre-edge PWM count is below 8
    led_in = 4'b0101;
    wait_level(2, 8, "duty_reach8");
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("duty8", 32'(led_out[2]), 32'(((m_pwm + LMAX) % (LMAX + 1)) < 8));
    end
    $display("duty: level2=%0d led_out=%b", get_level(2), led_out);

    // Reset mid-fade at level 7
    enable = 1'b0;
    led_in = 4'b0000;
    cyc(3);
    enable = 1'b1;
    led_in = 4'b0001;
    wait_level(0, 7, "midreset_reach7");
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_led_out", 32'(led_out), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_level", 32'(get_level(0)), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    check("restart_level_hold", 32'(get_level(0)), 32'd0);
    cyc(1);
    check("restart_level_1", 32'(get_level(0)), 32'd1);
    $display("mid-fade reset: level0=%0d led_out=%b", get_level(0), led_out);

    // Randomised targets and mode changes against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) led_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      cyc(1);
    end
    $display("random: final led_in=%b enable=%b led_out=%b busy=%b", led_in, enable, led_out, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream stage of the LED PIO slave: consumes its out_port bits as per-LED on/off targets and drives the physical LED pins.
- Each LED fades smoothly between off and full brightness using a per-channel brightness ramp and a shared PWM comparator.
- Same clock domain as the Avalon PIO. Sits between the PIO's out_port and the top-level LED pins.

Parameters:
- N_LEDS, 4, number of LED channels; equals the PIO out_port width.
- PWM_BITS, 8, width of the PWM counter and brightness level; LEVEL_MAX = 2^PWM_BITS-1.
- FADE_DIV, 50000, clocks per fade step (tick period); must be >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- led_in  in  N_LEDS  on/off targets, driven by the PIO out_port.
- enable  in  1  1 = fade mode; 0 = bypass, LEDs follow led_in directly.
- led_out  out  N_LEDS  LED pin drive, registered.
- busy  out  1  high while any channel level differs from its target extreme.

Behaviour:
- Reset (asynchronous, reset_n=0): clear all registers. led_out=0, busy=0, every level=0, PWM counter=0, prescaler=0, led_in_r=0.
- Input stage: led_in_r <= led_in every clock (1-cycle register). All targets come from led_in_r.
- Prescaler: counts 0..FADE_DIV-1 while enable=1. tick=1 for one cycle when the count equals FADE_DIV-1, then the count wraps to 0. Held at 0 while enable=0.
- PWM counter: PWM_BITS wide, free-running (+1 every clock), wraps LEVEL_MAX->0, independent of enable.
- Per-channel level update, on tick:
  - target=1 and level<LEVEL_MAX: level+1.
  - target=0 and level>0: level-1.
  - Otherwise hold. Saturating; no wrap ever.
- Direction reversal mid-fade: when a target changes, the ramp reverses at the next tick, starting from the current level. No snap.
- PWM output: led_out[i] <= (level[i]==LEVEL_MAX) ? 1 : (pwm_cnt < level[i]).
  - level 0 gives constant 0.
  - LEVEL_MAX gives constant 1 (no 1-in-2^B glitch).
  - Level L gives duty L/2^PWM_BITS.
- Bypass (enable=0):
  - Each level is forced every clock to LEVEL_MAX when led_in_r[i]=1, else 0.
  - led_out[i] <= led_in_r[i]. Latency from led_in to led_out is 2 clocks.
  - busy=0 from the cycle after the levels are forced.
- enable 0->1: fading resumes from the forced levels. The prescaler starts at 0, so the first tick is FADE_DIV clocks later.
- busy: registered OR over channels of (level != (target ? LEVEL_MAX : 0)). Updated every clock.
- Latency: a led_in change becomes visible in level at the first tick at least 1 clock after it is registered. A full fade takes LEVEL_MAX ticks.
- Simultaneous target change and tick in the same cycle: the tick uses the new led_in_r value already registered.
- Reset mid-fade: all outputs go to 0 immediately (asynchronous); the fade restarts from level 0 after release.

Decomposition:
- Shared package led_pkg holds:
  - LEVEL_MAX as a function of PWM_BITS;
  - the default FADE_DIV and PWM_BITS constants;
  - a level_t typedef (logic [PWM_BITS-1:0]).
- One sub-module, led_fade_channel, instantiated N_LEDS times.
  - Inputs: clk, reset_n, tick, enable, target, pwm_cnt.
  - Outputs: led, at_target.
  - Contains the level register, the saturating ramp and the PWM compare.
- The top level holds the input register, the prescaler, the PWM counter and the busy OR-reduction.

Test Plan:
All scenarios use N_LEDS=4, PWM_BITS=4, FADE_DIV=4.
- Reset: assert reset_n=0 with led_in=1111 -> led_out=0000, busy=0. After release with enable=0, led_out=1111 2 clocks later.
- Fade up: enable=1, led_in 0000->0001.
  - busy rises 2 clocks later.
  - level0 reaches 15 after 15 ticks (~60 clocks).
  - busy then falls and led_out[0] holds constant 1. Other LEDs stay 0.
- Duty: hold level0=8 by pulsing enable=0/1 appropriately, or force it via a bench hierarchical reference -> led_out[0] is high exactly 8 of every 16 clocks, aligned to pwm_cnt 0..7.
- Reversal: fade up led 1; at level1=5 set led_in[1]=0 -> next tick gives level 4, then it ramps down to 0 and busy falls at level 0.
- Bypass: enable=0, led_in=1010 -> led_out=1010 exactly 2 clocks later, busy=0. Toggling led_in bits gives a 2-clock-delayed mirror.
- Reset mid-fade: during a fade with level0=7, assert reset_n=0 -> led_out=0000 and busy=0 in the same cycle, without a clock edge. After release, level0 restarts from 0.
